// File: rtl/program_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_sequencer
// Description : Fetch-side program counter owner. Sequences jump / call /
//               return / halt requests from the decoder, issues push (o_call)
//               and pop (o_rtrn) strobes to the instruction stack, reloads the
//               PC from the stack's registered return address, and tracks the
//               live stack depth to trap overflow and underflow.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk     in   1                   clock, rising edge
//   i_rst     in   1                   asynchronous reset, active-low
//   i_en      in   1                   advance enable (RUN only)
//   i_jump    in   1                   load PC with i_target
//   i_call    in   1                   push current PC, load PC with i_target
//   i_rtrn    in   1                   pop stack, reload PC from i_stack
//   i_halt    in   1                   enter HALT
//   i_target  in   DATA_WIDTH          jump/call destination
//   i_stack   in   DATA_WIDTH          return address from stack (PC+1)
//   o_PC      out  DATA_WIDTH          current PC
//   o_call    out  1                   stack push strobe (combinational)
//   o_rtrn    out  1                   stack pop strobe (combinational)
//   o_busy    out  1                   high in RET_WAIT
//   o_depth   out  STACK_ADDR_WIDTH+1  live stack entries
//   o_halted  out  1                   high in HALT
//   o_err     out  2                   sticky: [0] overflow, [1] underflow
// ============================================================================
module program_counter_sequencer #(
    parameter int unsigned           DATA_WIDTH       = 16,
    parameter int unsigned           STACK_ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_jump,
    input  logic                        i_call,
    input  logic                        i_rtrn,
    input  logic                        i_halt,
    input  logic [DATA_WIDTH-1:0]       i_target,
    input  logic [DATA_WIDTH-1:0]       i_stack,
    output logic [DATA_WIDTH-1:0]       o_PC,
    output logic                        o_call,
    output logic                        o_rtrn,
    output logic                        o_busy,
    output logic [STACK_ADDR_WIDTH:0]   o_depth,
    output logic                        o_halted,
    output logic [1:0]                  o_err
);

    // Depth value at which the stack holds 2**STACK_ADDR_WIDTH entries.
    localparam logic [STACK_ADDR_WIDTH:0] c_depth_full = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};
    localparam logic [STACK_ADDR_WIDTH:0] c_depth_one  = {{STACK_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]     c_pc_one     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t                      r_state;
    logic [DATA_WIDTH-1:0]       r_pc;
    logic [STACK_ADDR_WIDTH:0]   r_depth;
    logic [1:0]                  r_err;
    logic                        r_busy;
    logic                        r_halted;

    logic w_run_active;
    logic w_req_halt;
    logic w_req_rtrn;
    logic w_req_call;
    logic w_req_jump;
    logic w_req_inc;
    logic w_empty;
    logic w_full;

    // ------------------------------------------------------------------
    // Request decode. Exactly one w_req_* is high when RUN and enabled,
    // following halt > rtrn > call > jump > increment. Reset gating keeps
    // the strobes quiet while i_rst is held low.
    // ------------------------------------------------------------------
    assign w_run_active = i_rst && (r_state == S_RUN) && i_en;
    assign w_req_halt   = w_run_active &&  i_halt;
    assign w_req_rtrn   = w_run_active && !i_halt &&  i_rtrn;
    assign w_req_call   = w_run_active && !i_halt && !i_rtrn &&  i_call;
    assign w_req_jump   = w_run_active && !i_halt && !i_rtrn && !i_call &&  i_jump;
    assign w_req_inc    = w_run_active && !i_halt && !i_rtrn && !i_call && !i_jump;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == c_depth_full);

    // Strobes are combinational so the stack acts on the same edge that
    // updates the PC; a trapped request never reaches the stack.
    assign o_rtrn = w_req_rtrn && !w_empty;
    assign o_call = w_req_call && !w_full;

    // ------------------------------------------------------------------
    // Sequencer state machine with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_depth  <= '0;
            r_err    <= 2'b00;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_req_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_req_rtrn) begin
                        if (!w_empty) begin
                            // PC holds; the stack registers the return
                            // address on this edge and it is loaded next.
                            r_depth <= r_depth - c_depth_one;
                            r_state <= S_RET_WAIT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err[1] <= 1'b1;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (w_req_call) begin
                        if (!w_full) begin
                            r_depth <= r_depth + c_depth_one;
                            r_pc    <= i_target;
                        end else begin
                            r_err[0] <= 1'b1;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (w_req_jump) begin
                        r_pc <= i_target;
                    end else if (w_req_inc) begin
                        // Natural wrap from all-ones to zero.
                        r_pc <= r_pc + c_pc_one;
                    end
                end

                S_RET_WAIT: begin
                    r_pc    <= i_stack;
                    r_state <= S_RUN;
                    r_busy  <= 1'b0;
                end

                S_HALT: begin
                    // Frozen until reset.
                end

                default: begin
                    // Unused encoding: park safely in HALT.
                    r_state  <= S_HALT;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign o_PC     = r_pc;
    assign o_busy   = r_busy;
    assign o_depth  = r_depth;
    assign o_halted = r_halted;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter_sequencer
// Description : Scoreboard bench for program_counter_sequencer. A driver
//               issues directed and random decoder requests and pushes the
//               expected per-cycle outputs from a queue-based reference model;
//               a monitor pops and compares mid-cycle. A small behavioural
//               instruction stack (stores PC+1, registered pop data) closes
//               the loop around the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_program_counter_sequencer;

    localparam int unsigned c_dw  = 16;
    localparam int unsigned c_saw = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_en = 1'b0, i_jump = 1'b0, i_call = 1'b0, i_rtrn = 1'b0, i_halt = 1'b0;
    logic [c_dw-1:0]   i_target = '0;
    logic [c_dw-1:0]   i_stack;
    logic [c_dw-1:0]   o_PC;
    logic              o_call, o_rtrn, o_busy, o_halted;
    logic [c_saw:0]    o_depth;
    logic [1:0]        o_err;

    always #5 i_clk = ~i_clk;

    program_counter_sequencer #(
        .DATA_WIDTH       (c_dw),
        .STACK_ADDR_WIDTH (c_saw),
        .RESET_PC         (16'h0000)
    ) u_dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_jump   (i_jump),
        .i_call   (i_call),
        .i_rtrn   (i_rtrn),
        .i_halt   (i_halt),
        .i_target (i_target),
        .i_stack  (i_stack),
        .o_PC     (o_PC),
        .o_call   (o_call),
        .o_rtrn   (o_rtrn),
        .o_busy   (o_busy),
        .o_depth  (o_depth),
        .o_halted (o_halted),
        .o_err    (o_err)
    );

    // ---------------- behavioural instruction stack ----------------------
    logic [c_dw-1:0] r_stk [16];
    int              r_sp;
    logic [c_dw-1:0] r_stack_q;

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sp      <= 0;
            r_stack_q <= '0;
        end else if (o_call && r_sp < 16) begin
            r_stk[r_sp] <= o_PC + 16'd1;
            r_sp        <= r_sp + 1;
        end else if (o_rtrn && r_sp > 0) begin
            r_stack_q <= r_stk[r_sp-1];
            r_sp      <= r_sp - 1;
        end
    end
    assign i_stack = r_stack_q;

    // ---------------- reference model and scoreboard --------------------
    typedef struct {
        logic [15:0] pc;
        logic [4:0]  depth;
        logic        busy;
        logic        halted;
        logic [1:0]  err;
        logic        call;
        logic        rtrn;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_ret[$];
    logic [15:0] m_pc;
    logic [15:0] m_pend;
    logic        m_wait;
    logic        m_halted;
    logic [1:0]  m_err;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t reset_rec();
        exp_t e;
        e.pc = 16'h0000; e.depth = 5'd0; e.busy = 1'b0; e.halted = 1'b0;
        e.err = 2'b00; e.call = 1'b0; e.rtrn = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_en = 1'b0; i_jump = 1'b0; i_call = 1'b0; i_rtrn = 1'b0; i_halt = 1'b0;
        m_pc = 16'h0000; m_wait = 1'b0; m_halted = 1'b0; m_err = 2'b00;
        m_ret.delete();
        sbq.push_back(reset_rec());
    endtask

    // One decoder cycle: expected outputs for this cycle are recorded,
    // then the model moves to the state it must hold after the edge.
    task automatic drive(input logic en, input logic jump, input logic call,
                         input logic rtrn, input logic halt, input logic [15:0] tgt);
        exp_t e;
        @(negedge i_clk);
        i_rst = 1'b1;
        i_en = en; i_jump = jump; i_call = call; i_rtrn = rtrn; i_halt = halt;
        i_target = tgt;
        e.pc = m_pc; e.depth = 5'(m_ret.size()); e.busy = m_wait;
        e.halted = m_halted; e.err = m_err; e.call = 1'b0; e.rtrn = 1'b0;
        if (m_wait) begin
            m_pc   = m_pend;
            m_wait = 1'b0;
        end else if (!m_halted && en) begin
            if (halt) begin
                m_halted = 1'b1;
            end else if (rtrn) begin
                if (m_ret.size() > 0) begin
                    e.rtrn = 1'b1;
                    m_pend = m_ret.pop_back();
                    m_wait = 1'b1;
                end else begin
                    m_err[1] = 1'b1;
                    m_halted = 1'b1;
                end
            end else if (call) begin
                if (m_ret.size() < 16) begin
                    e.call = 1'b1;
                    m_ret.push_back(m_pc + 16'd1);
                    m_pc = tgt;
                end else begin
                    m_err[0] = 1'b1;
                    m_halted = 1'b1;
                end
            end else if (jump) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // ---------------- monitor -------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc",     32'(o_PC),     32'(e.pc));
                chk("depth",  32'(o_depth),  32'(e.depth));
                chk("busy",   32'(o_busy),   32'(e.busy));
                chk("halted", 32'(o_halted), 32'(e.halted));
                chk("err",    32'(o_err),    32'(e.err));
                chk("call",   32'(o_call),   32'(e.call));
                chk("rtrn",   32'(o_rtrn),   32'(e.rtrn));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ------------------------------------------
    initial begin
        // T1: reset then plain increments
        do_reset();
        repeat (3) idle();

        // T2: call/return around PC 10
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd40);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        idle();

        // T3: nine nested calls then nine returns (junk requests in RET_WAIT)
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(k * 16'h10));
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h100 + (k - 1) * 16'h10));
        end
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'($urandom));
        end
        idle();

        // T4: fill to 16, then overflow and confirm freeze
        do_reset();
        for (int k = 0; k < 16; k++)
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        repeat (3) drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 16'($urandom));

        // T5: underflow, then call+rtrn together at depth 0
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        idle();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0055);
        idle();

        // T6: wrap, enable hold, reset mid-return
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        idle();
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0700);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        do_reset();
        repeat (2) idle();

        // Random phase
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m_halted && $urandom_range(0, 2) == 0) begin
                do_reset();
            end else begin
                logic [15:0] tgt;
                tgt = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                  : 16'($urandom);
                drive($urandom_range(0, 9) != 0,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 2,
                      tgt);
            end
        end

        @(negedge i_clk);
        #5;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
